// File: rtl/instr_issue_unit.sv
// instr_issue_unit
//   Issue-side partner of the 16-bit-instruction compute unit. A short program
//   is loaded byte-serially (high byte first) into a small buffer. On start,
//   the words are issued one at a time. After each instruction that produces a
//   writeback, the unit waits for that writeback and checks it. The latest
//   result and the run status are presented to the chip outputs.
//   The instruction bus stays at NOP (16'h0000) whenever nothing is being
//   issued, because the compute unit executes its input on every enabled cycle.
//
// Optional feature:
//   ISSUE_CYCLE_COUNT_EN adds cycle_count[15:0]. It counts enabled ISSUE/WAIT
//   cycles, saturates at 16'hFFFF and is cleared by an accepted start.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ena                   global enable; low freezes all state
//   load_byte, load_valid program byte stream, accepted in IDLE only
//   start                 level start request, acted on in IDLE only
//   instruction           to the compute unit; 16'h0000 except in the issue cycle
//   instr_valid           high during the issue cycle
//   data, data_valid      writeback from the compute unit
//   reg_id                writeback target register
//   result_data           data of the last accepted writeback
//   result_reg            register of the last accepted writeback
//   result_valid          one-cycle pulse per accepted writeback
//   busy                  high in ISSUE/WAIT
//   done                  one-cycle pulse when a run ends
//   error                 sticky fault flag (timeout or wrong reg_id)
//   pc                    current program counter
//   cycle_count           (ISSUE_CYCLE_COUNT_EN only) issue/wait cycle count
module instr_issue_unit #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  input  logic              start,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic [7:0]        data,
  input  logic              data_valid,
  input  logic [3:0]        reg_id,
  output logic [7:0]        result_data,
  output logic [3:0]        result_reg,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
`ifdef ISSUE_CYCLE_COUNT_EN
  output logic [15:0]       cycle_count,
`endif
  output logic [ADDR_W-1:0] pc
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int TMO_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_END} state_t;

  function automatic logic [LEN_W-1:0] sat_len_inc(input logic [LEN_W-1:0] v);
    if (v == LEN_W'(PROG_DEPTH)) return v;
    return v + LEN_W'(1);
  endfunction

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   load_ptr, load_ptr_d;
  logic [LEN_W-1:0]    prog_len, prog_len_d;
  logic                byte_phase, byte_phase_d;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
  logic                error_d;
  logic [7:0]          result_data_d;
  logic [3:0]          result_reg_d;
  logic                rv_p1, rv_d;
  logic                hi_we, mem_we;
  logic [7:0]          hi_byte;
  logic [15:0]         mem [PROG_DEPTH];
  logic [15:0]         cur_word;
  logic [3:0]          op;
  logic                last_word;

  // pc holds during WAIT and memory is only written in IDLE, so mem[pc]
  // is still the outstanding instruction while its writeback is awaited.
  assign cur_word  = mem[pc];
  assign op        = cur_word[15:12];
  assign last_word = (({1'b0, pc} + LEN_W'(1)) == prog_len);

  assign busy         = (state == S_ISSUE) || (state == S_WAIT);
  assign result_valid = rv_p1 & ena;

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    load_ptr_d    = load_ptr;
    prog_len_d    = prog_len;
    byte_phase_d  = byte_phase;
    tmo_cnt_d     = tmo_cnt;
    error_d       = error;
    result_data_d = result_data;
    result_reg_d  = result_reg;
    rv_d          = 1'b0;
    hi_we         = 1'b0;
    mem_we        = 1'b0;
    instruction   = 16'h0000;
    instr_valid   = 1'b0;
    done          = 1'b0;
    if (ena) begin
      unique case (state)
        S_IDLE: begin
          // start takes priority; a byte arriving with it is dropped
          if (start) begin
            if (prog_len != '0) begin
              error_d = 1'b0;
              pc_d    = '0;
              state_d = S_ISSUE;
            end else begin
              done = 1'b1;
            end
          end else if (load_valid) begin
            byte_phase_d = ~byte_phase;
            if (!byte_phase) begin
              hi_we = 1'b1;
            end else begin
              mem_we     = 1'b1;
              load_ptr_d = load_ptr + ADDR_W'(1);
              prog_len_d = sat_len_inc(prog_len);
            end
          end
        end
        S_ISSUE: begin
          if (op == 4'hF) begin
            state_d = S_END;
          end else begin
            instruction = cur_word;
            instr_valid = 1'b1;
            if (op != 4'h0 && !op[3]) begin
              tmo_cnt_d = '0;
              state_d   = S_WAIT;
            end else if (last_word) begin
              state_d = S_END;
            end else begin
              pc_d = pc + ADDR_W'(1);
            end
          end
        end
        S_WAIT: begin
          // a writeback is checked before the timeout, so data arriving on
          // the cycle the counter hits TIMEOUT is still accepted
          if (data_valid) begin
            if (reg_id == cur_word[11:8]) begin
              result_data_d = data;
              result_reg_d  = reg_id;
              rv_d          = 1'b1;
              if (last_word) begin
                state_d = S_END;
              end else begin
                pc_d    = pc + ADDR_W'(1);
                state_d = S_ISSUE;
              end
            end else begin
              error_d = 1'b1;
              state_d = S_END;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
            error_d = 1'b1;
            state_d = S_END;
          end else begin
            tmo_cnt_d = tmo_cnt + TMO_W'(1);
          end
        end
        S_END: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      load_ptr    <= '0;
      prog_len    <= '0;
      byte_phase  <= 1'b0;
      tmo_cnt     <= '0;
      error       <= 1'b0;
      result_data <= '0;
      result_reg  <= '0;
      rv_p1       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      load_ptr    <= load_ptr_d;
      prog_len    <= prog_len_d;
      byte_phase  <= byte_phase_d;
      tmo_cnt     <= tmo_cnt_d;
      error       <= error_d;
      result_data <= result_data_d;
      result_reg  <= result_reg_d;
      rv_p1       <= rv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hi_we)  hi_byte       <= load_byte;
    if (mem_we) mem[load_ptr] <= {hi_byte, load_byte};
  end

`ifdef ISSUE_CYCLE_COUNT_EN
  function automatic logic [15:0] sat_cnt16_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  logic [15:0] cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count;
    if (ena) begin
      if (state == S_IDLE && start && prog_len != '0)
        cycle_count_d = '0;
      else if (state == S_ISSUE || state == S_WAIT)
        cycle_count_d = sat_cnt16_inc(cycle_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_count <= '0;
    else     cycle_count <= cycle_count_d;
  end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed testbench for instr_issue_unit with a scripted compute-unit responder.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst, ena, load_valid, start, data_valid;
  logic [7:0]  load_byte, data;
  logic [3:0]  reg_id;
  logic [15:0] instruction;
  logic        instr_valid, result_valid, busy, done, error;
  logic [7:0]  result_data;
  logic [3:0]  result_reg;
  logic [3:0]  pc;
`ifdef ISSUE_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          iv_cnt = 0, rv_cnt = 0, done_cnt = 0;
  logic [15:0] issued_q[$];
  logic [7:0]  resp_q[$];

  always #5 clk = ~clk;

  instr_issue_unit #(.PROG_DEPTH(16), .ADDR_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .load_byte(load_byte), .load_valid(load_valid), .start(start),
    .instruction(instruction), .instr_valid(instr_valid),
    .data(data), .data_valid(data_valid), .reg_id(reg_id),
    .result_data(result_data), .result_reg(result_reg), .result_valid(result_valid),
    .busy(busy), .done(done), .error(error),
`ifdef ISSUE_CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .pc(pc)
  );

  always @(negedge clk) begin
    if (instr_valid) begin
      iv_cnt++;
      issued_q.push_back(instruction);
    end
    if (result_valid) rv_cnt++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    data_valid = 1'b0; data = 8'h00; reg_id = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte = b; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: never respond; 1: respond next cycle with the right reg_id and the
  // next resp_q byte; 2: respond next cycle with reg_id one above the target.
  // cyc counts edges from the start edge to the edge that entered END.
  task automatic run_prog(input int mode, input int budget, output int cyc);
    logic        pend, got_done;
    logic [15:0] iw;
    pend = 1'b0; got_done = 1'b0; iw = 16'h0; cyc = 0;
    pulse_start();
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mode != 0 && instr_valid && instruction[15:12] != 4'h0 && !instruction[15]) begin
        pend = 1'b1;
        iw   = instruction;
      end
      @(posedge clk); #1;
      cyc++;
      data_valid = 1'b0;
      if (pend) begin
        data_valid = 1'b1;
        reg_id     = (mode == 2) ? iw[11:8] + 4'd1 : iw[11:8];
        data       = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        pend       = 1'b0;
      end
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    check_eq("run_done_seen", {31'b0, got_done}, 32'd1);
  endtask

  initial begin
    int cyc, iv0, rv0, dn0, q0;

    // reset state
    do_reset();
    check_eq("rst_instruction", instruction, 32'h0);
    check_eq("rst_instr_valid", instr_valid, 32'h0);
    check_eq("rst_result_data", result_data, 32'h0);
    check_eq("rst_result_reg", result_reg, 32'h0);
    check_eq("rst_result_valid", result_valid, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_done", done, 32'h0);
    check_eq("rst_error", error, 32'h0);
    check_eq("rst_pc", pc, 32'h0);

    // three LOAD/ADD words with one-cycle responses
    iv0 = iv_cnt; rv0 = rv_cnt; dn0 = done_cnt; q0 = issued_q.size();
    load_word(16'h1205); load_word(16'h1307); load_word(16'h2345);
    resp_q = '{8'h05, 8'h07, 8'h0C};
    run_prog(1, 100, cyc);
    check_eq("t1_issue0", issued_q[q0], 32'h1205);
    check_eq("t1_issue1", issued_q[q0+1], 32'h1307);
    check_eq("t1_issue2", issued_q[q0+2], 32'h2345);
    check_eq("t1_iv_pulses", iv_cnt - iv0, 32'd3);
    check_eq("t1_rv_pulses", rv_cnt - rv0, 32'd3);
    check_eq("t1_done_pulses", done_cnt - dn0, 32'd1);
    check_eq("t1_result_reg", result_reg, 32'h3);
    check_eq("t1_result_data", result_data, 32'h0C);
    check_eq("t1_error", error, 32'h0);
    check_eq("t1_pc", pc, 32'd2);
    check_eq("t1_cycles", cyc, 32'd6);
    check_eq("t1_busy_after", busy, 32'h0);
`ifdef ISSUE_CYCLE_COUNT_EN
    check_eq("t1_cycle_count", cycle_count, 32'd6);
`endif

    // NOP, LOAD r10, HALT
    do_reset();
    iv0 = iv_cnt; rv0 = rv_cnt; dn0 = done_cnt; q0 = issued_q.size();
    load_word(16'h0000); load_word(16'h1A33); load_word(16'hF000);
    resp_q = '{8'h33};
    run_prog(1, 100, cyc);
    check_eq("t2_iv_pulses", iv_cnt - iv0, 32'd2);
    check_eq("t2_issue0", issued_q[q0], 32'h0000);
    check_eq("t2_issue1", issued_q[q0+1], 32'h1A33);
    check_eq("t2_result_reg", result_reg, 32'hA);
    check_eq("t2_result_data", result_data, 32'h33);
    check_eq("t2_done_pulses", done_cnt - dn0, 32'd1);
    check_eq("t2_pc", pc, 32'd2);
    check_eq("t2_cycles", cyc, 32'd4);

    // timeout: ISSUE edge, then TIMEOUT+1 = 16 WAIT cycles, then END -> cyc 17
    do_reset();
    iv0 = iv_cnt; rv0 = rv_cnt; dn0 = done_cnt;
    load_word(16'h1401);
    run_prog(0, 100, cyc);
    check_eq("t3_cycles", cyc, 32'd17);
    check_eq("t3_error", error, 32'h1);
    check_eq("t3_rv_pulses", rv_cnt - rv0, 32'd0);
    check_eq("t3_done_pulses", done_cnt - dn0, 32'd1);
    resp_q = '{8'h01};
    run_prog(1, 100, cyc);
    check_eq("t3_restart_error", error, 32'h0);
    check_eq("t3_restart_data", result_data, 32'h01);

    // wrong reg_id
    do_reset();
    rv0 = rv_cnt; dn0 = done_cnt;
    load_word(16'h1401);
    run_prog(2, 100, cyc);
    check_eq("t4_error", error, 32'h1);
    check_eq("t4_rv_pulses", rv_cnt - rv0, 32'd0);
    check_eq("t4_done_pulses", done_cnt - dn0, 32'd1);
    check_eq("t4_result_reg", result_reg, 32'h0);

    // ena low freezes the WAIT timeout counter
    do_reset();
    dn0 = done_cnt;
    load_word(16'h1401);
    pulse_start();
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_frozen_busy", busy, 32'h1);
    check_eq("t5_frozen_error", error, 32'h0);
    check_eq("t5_frozen_done", done_cnt - dn0, 32'd0);
    ena = 1'b1; data_valid = 1'b1; reg_id = 4'h4; data = 8'hA5;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check_eq("t5_result_valid", result_valid, 32'h1);
    check_eq("t5_result_data", result_data, 32'hA5);
    check_eq("t5_error", error, 32'h0);

    // writeback in the cycle the counter reaches TIMEOUT is accepted
    do_reset();
    load_word(16'h1401);
    pulse_start();
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1 data_valid = 1'b1; reg_id = 4'h4; data = 8'h5A;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check_eq("t6_boundary_error", error, 32'h0);
    check_eq("t6_boundary_data", result_data, 32'h5A);
    check_eq("t6_boundary_done", done, 32'h1);

    // rst during ISSUE
    do_reset();
    load_word(16'h1205); load_word(16'h1307);
    pulse_start();
    check_eq("t7_issue_instr", instruction, 32'h1205);
    dn0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t7_instruction", instruction, 32'h0);
    check_eq("t7_instr_valid", instr_valid, 32'h0);
    check_eq("t7_busy", busy, 32'h0);
    check_eq("t7_pc", pc, 32'h0);
    repeat (3) @(posedge clk);
    #1 check_eq("t7_no_done", done_cnt - dn0, 32'd0);

    // start with empty program; a byte in the same cycle is dropped
    do_reset();
    start = 1'b1; load_valid = 1'b1; load_byte = 8'h77;
    #1 check_eq("t8_empty_done", done, 32'h1);
    @(posedge clk); #1;
    start = 1'b0; load_valid = 1'b0;
    check_eq("t8_empty_busy", busy, 32'h0);
`ifdef ISSUE_CYCLE_COUNT_EN
    check_eq("t8_cycle_count", cycle_count, 32'd0);
`endif
    q0 = issued_q.size();
    load_word(16'h1234);
    resp_q = '{8'h34};
    run_prog(1, 100, cyc);
    check_eq("t8_byte_dropped", issued_q[q0], 32'h1234);

    // full 16-word program of NOPs: last word at index 15
    do_reset();
    iv0 = iv_cnt; q0 = issued_q.size();
    for (int i = 0; i < 16; i++) load_word({4'h0, 4'(i), 8'hA0});
    run_prog(0, 100, cyc);
    check_eq("t9_iv_pulses", iv_cnt - iv0, 32'd16);
    check_eq("t9_first", issued_q[q0], 32'h00A0);
    check_eq("t9_last", issued_q[q0+15], 32'h0FA0);
    check_eq("t9_pc", pc, 32'd15);
    check_eq("t9_cycles", cyc, 32'd16);
`ifdef ISSUE_CYCLE_COUNT_EN
    check_eq("t9_cycle_count", cycle_count, 32'd16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Issue-side partner of the 16-bit-instruction compute unit.
- Buffers a small program loaded byte-serially from the pads and issues one instruction at a time on the compute unit's instruction bus.
- Waits for each writeback (data/data_valid/reg_id), checks it, and exposes the latest result plus run status to the chip outputs.
- Holds the compute unit's instruction bus at NOP (16'h0000) whenever it is not issuing, because the compute unit executes its input every enabled cycle.

Parameters:
- PROG_DEPTH, 16, number of 16-bit program words; power of two.
- ADDR_W, 4, log2(PROG_DEPTH); width of the load pointer and pc.
- TIMEOUT, 15, maximum WAIT cycles before a missing writeback is flagged; fits in 4 bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- ena  input  1  global enable; low freezes the block
- load_byte  input  8  program byte; high byte of each word first
- load_valid  input  1  load_byte valid this cycle
- start  input  1  start run; level, acted on in IDLE only
- instruction  output  16  to compute unit; 16'h0000 except in the issue cycle
- instr_valid  output  1  high during the issue cycle
- data  input  8  writeback data from compute unit
- data_valid  input  1  writeback valid
- reg_id  input  4  writeback target register
- result_data  output  8  last accepted writeback data
- result_reg  output  4  last accepted writeback register
- result_valid  output  1  one-cycle pulse per accepted writeback
- busy  output  1  high in ISSUE/WAIT
- done  output  1  one-cycle pulse on run end
- error  output  1  sticky fault flag
- pc  output  ADDR_W  current program counter

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. pc, load pointer, prog_len and the byte-phase flag are 0. Program memory contents are not reset.
- ena low: no state changes, no counting. instruction=0, instr_valid=0, result_valid=0, done=0.
- FSM states: IDLE, ISSUE, WAIT, END.
- IDLE, load path:
  - Each load_valid byte toggles the byte-phase flag. The first byte latches as the high byte; the second writes {hi,lo} to mem[load_ptr].
  - After each word write: load_ptr increments and wraps at PROG_DEPTH. prog_len increments and saturates at PROG_DEPTH.
  - load_valid outside IDLE is ignored and does not change the byte-phase flag.
- IDLE, start path:
  - start=1 with prog_len>0: clear error and pc, go to ISSUE.
  - start=1 with prog_len==0: pulse done, stay in IDLE.
  - If start and load_valid occur in the same cycle, start wins and the byte is dropped.
- ISSUE: opcode op=mem[pc][15:12].
  - op==4'hF (HALT): nothing is issued; go to END.
  - Otherwise drive instruction=mem[pc] and instr_valid=1 for exactly one cycle.
  - op in 1..7: load timeout counter=0, go to WAIT.
  - op 0 or 8..E (no writeback expected): advance pc, then go to END if pc+1==prog_len, else stay in ISSUE.
- WAIT: instruction=0.
  - data_valid=1 and reg_id==issued[11:8]: capture result_data=data and result_reg=reg_id, pulse result_valid next cycle, advance pc, go to ISSUE, or to END if pc+1==prog_len.
  - data_valid=1 with a mismatched reg_id: set error, go to END.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set error and go to END.
  - First-cycle writeback: a data_valid arriving in the very first WAIT cycle (the issue cycle's registered response) is accepted.
- END: pulse done, go to IDLE. pc holds its final value. error remains sticky until the next accepted start or rst.
- Exact-boundary case: a writeback arriving in the same cycle the counter reaches TIMEOUT is accepted with no error. Data beats the timeout.
- rst mid-run: block returns to IDLE in the same edge. instruction is 0 on the next cycle. No done pulse.
- Wrap: pc never exceeds prog_len-1. With PROG_DEPTH words loaded, the last word is at index PROG_DEPTH-1.

Optional Feature:
- Macro ISSUE_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycle_count[15:0].
  - Clears on accepted start.
  - Increments every enabled cycle in ISSUE or WAIT and saturates at 16'hFFFF.
  - Holds its value after END.
  - Resets to 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Load bytes 12,05,13,07,23,45 (3 words), start -> issues 16'h1205, 16'h1307, 16'h2345.
  - With a compute-unit model responding the following cycle: result_valid pulses 3×, final result_reg=3, result_data=8'h0C, done pulse, error=0, pc=2.
- Program 16'h0000, 16'h1A33, 16'hF000, start -> NOP issued with no WAIT; LOAD waits and accepts reg 10 data 8'h33; HALT ends the run. Exactly 2 instr_valid pulses, then done.
- Load 16'h1401, start, model never asserts data_valid -> error=1 and done exactly TIMEOUT+1 cycles after the WAIT entry. Next start clears error.
- Writeback with reg_id=5 while 16'h1401 (target 4) is outstanding -> error=1, done pulse, result_valid stays 0.
- Hold ena=0 for 5 cycles during WAIT, then respond -> no timeout, state frozen, result accepted after re-enable. Also assert rst mid-ISSUE -> instruction=0 and outputs 0 next cycle.
- ISSUE_CYCLE_COUNT_EN defined, 3-word LOAD program with 1-cycle responses -> cycle_count=6 at done. Start with prog_len=0 -> immediate done, count unchanged.
